// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: a PC register, the IF/ID pipeline register and a BOOT/RUN/HALTED FSM.
// Optional feature: define IFU_STALL_COUNT_EN to add a saturating 16-bit stall_cnt output.
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned IMEM_WORDS = 64
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_data,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        halt,
   output logic [31:0] if_id_pc,
   output logic [31:0] if_id_instr,
   output logic        if_id_valid,
   output logic [1:0]  fetch_state
`ifdef IFU_STALL_COUNT_EN
   ,
   output logic [15:0] stall_cnt
`endif
);

   // Byte-address mask of the instruction memory; IMEM_WORDS is a power of two.
   localparam logic [31:0] PcMask = 32'(4 * IMEM_WORDS - 1);

   typedef enum logic [1:0] {
      StBoot   = 2'd0,
      StRun    = 2'd1,
      StHalted = 2'd2,
      StBad    = 2'd3
   } state_e;

   state_e      state_q;
   logic [31:0] pc_q;
   logic [31:0] if_id_pc_q;
   logic [31:0] if_id_instr_q;
   logic        if_id_valid_q;

   logic [31:0] pc_inc;
   logic [31:0] redir_target;

   always_comb begin
      pc_inc       = (pc_q + 32'd4) & PcMask;
      // Clearing the low two bits word-aligns the target before wrapping it into memory.
      redir_target = redirect_pc & ~32'h0000_0003 & PcMask;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= StBoot;
         pc_q          <= RESET_PC;
         if_id_pc_q    <= 32'd0;
         if_id_instr_q <= 32'd0;
         if_id_valid_q <= 1'b0;
      end else begin
         case (state_q)
            StBoot: begin
               state_q <= StRun;
            end
            StRun: begin
               if (redirect) begin
                  pc_q          <= redir_target;
                  if_id_pc_q    <= 32'd0;
                  if_id_instr_q <= 32'd0;
                  if_id_valid_q <= 1'b0;
               end else if (stall) begin
                  pc_q <= pc_q;
               end else begin
                  if_id_pc_q    <= pc_q;
                  if_id_instr_q <= imem_data;
                  if_id_valid_q <= 1'b1;
                  if (halt) begin
                     // The instruction at PC is consumed but PC itself stays put.
                     state_q <= StHalted;
                  end else begin
                     pc_q <= pc_inc;
                  end
               end
            end
            StHalted: begin
               if_id_pc_q    <= 32'd0;
               if_id_instr_q <= 32'd0;
               if_id_valid_q <= 1'b0;
               if (redirect) begin
                  pc_q    <= redir_target;
                  state_q <= StRun;
               end
            end
            default: begin
               state_q <= StBoot;
            end
         endcase
      end
   end

   assign imem_addr   = pc_q;
   assign if_id_pc    = if_id_pc_q;
   assign if_id_instr = if_id_instr_q;
   assign if_id_valid = if_id_valid_q;
   assign fetch_state = state_q;

`ifdef IFU_STALL_COUNT_EN
   logic [15:0] stall_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q <= 16'd0;
      end else if (state_q == StRun && stall && !redirect && stall_cnt_q != 16'hFFFF) begin
         stall_cnt_q <= stall_cnt_q + 16'd1;
      end
   end

   assign stall_cnt = stall_cnt_q;
`endif

endmodule
